seg_capture: RTL

SEG_CAPTURE -- requirements
Module: seg_capture

---
 rtl/seg_capture.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/seg_capture.sv
// Seven-segment capture: debounces a sampled {digit_sel, segment} pattern and decodes it to BCD (hex A-F when SEG_CAPTURE_HEX_EN is defined).
// Latency: a pattern sampled at edge k pulses o_Valid/o_Error in the cycle after edge k+STABLE_CYCLES; no backpressure.
module seg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [6:0] i_Segment,
  input  logic       i_Digit_Sel,
  output logic [3:0] o_Ones,
  output logic [3:0] o_Tens,
  output logic       o_Valid,
  output logic       o_Error,
  output logic [7:0] o_Err_Count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [6:0] BLANK    = 7'b1111111;
  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

`ifdef SEG_CAPTURE_HEX_EN
  localparam logic HEX_EN = 1'b1;
`else
  localparam logic HEX_EN = 1'b0;
`endif

  // Returns {recognized, value}; letter patterns are recognized only in the hex build.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    logic [4:0] r;
    r = 5'b0;
    case (seg)
      7'b1000000: r = {1'b1, 4'd0};
      7'b1111001: r = {1'b1, 4'd1};
      7'b0100100: r = {1'b1, 4'd2};
      7'b0110000: r = {1'b1, 4'd3};
      7'b0011001: r = {1'b1, 4'd4};
      7'b0010010: r = {1'b1, 4'd5};
      7'b0000010: r = {1'b1, 4'd6};
      7'b1111000: r = {1'b1, 4'd7};
      7'b0000000: r = {1'b1, 4'd8};
      7'b0010000: r = {1'b1, 4'd9};
      7'b0001000: r = {HEX_EN, 4'd10};
      7'b0000011: r = {HEX_EN, 4'd11};
      7'b1000110: r = {HEX_EN, 4'd12};
      7'b0100001: r = {HEX_EN, 4'd13};
      7'b0000110: r = {HEX_EN, 4'd14};
      7'b0001110: r = {HEX_EN, 4'd15};
      default:    r = 5'b0;
    endcase
    return r;
  endfunction

  logic [7:0] samp_q;
  logic [7:0] prev_q;
  state_t     state_q;
  state_t     state_d;
  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [3:0] ones_q;
  logic [3:0] tens_q;
  logic       valid_q;
  logic       error_q;
  logic [7:0] err_cnt_q;

  logic       samp_blank;
  logic       samp_same;
  logic       fire_d;
  logic       recog;
  logic [3:0] dec_val;

  always_comb begin
    samp_blank       = (samp_q[6:0] == BLANK);
    // Digit select is part of the compared word, so a select-only change restarts tracking.
    samp_same        = (samp_q == prev_q);
    {recog, dec_val} = decode(samp_q[6:0]);
    state_d          = state_q;
    cnt_d            = cnt_q;
    case (state_q)
      IDLE: begin
        if (!samp_blank) begin
          state_d = TRACK;
          cnt_d   = 8'd1;
        end
      end
      TRACK: begin
        if (samp_blank) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (samp_same) begin
          cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = 8'd1;
        end
      end
      LOCKED: begin
        if (samp_blank) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (!samp_same) begin
          state_d = TRACK;
          cnt_d   = 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    // Acceptance happens on the edge the count reaches the window, so a window of 1 fires straight from IDLE.
    fire_d = (state_d == TRACK) && (cnt_d == STABLE_N);
    if (fire_d) begin
      state_d = LOCKED;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      samp_q    <= {1'b0, BLANK};
      prev_q    <= {1'b0, BLANK};
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      ones_q    <= 4'd0;
      tens_q    <= 4'd0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      samp_q  <= {i_Digit_Sel, i_Segment};
      prev_q  <= samp_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= fire_d && recog;
      error_q <= fire_d && !recog;
      if (fire_d && recog) begin
        if (samp_q[7]) begin
          tens_q <= dec_val;
        end else begin
          ones_q <= dec_val;
        end
      end
      if (fire_d && !recog && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign o_Ones      = ones_q;
  assign o_Tens      = tens_q;
  assign o_Valid     = valid_q;
  assign o_Error     = error_q;
  assign o_Err_Count = err_cnt_q;

endmodule
